// File: rtl/dl_boot_ctrl.sv
// ============================================================================
// dl_boot_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Boot / download controller. The core is held in reset until every image
//   slot named in REQ_MASK has been downloaded. Once they are all present,
//   core_reset is stretched for RST_CYCLES clocks and then released. User
//   reset requests re-stretch the reset while the core is running. Download
//   writes are filtered by slot and address range, then forwarded one cycle
//   late on a registered write bus.
//
// Optional feature:
//   `define DL_CHECKSUM_EN adds output dl_sum, which is the modulo-256 sum of
//   the bytes forwarded during the current or most recent download.
//
// Parameters:
//   N_SLOTS    number of image slots (ioctl_index 0..N_SLOTS-1)
//   REQ_MASK   slots that must be loaded before the core may run
//   AW         width of the forwarded download address
//   RST_CYCLES minimum core_reset length in clk_sys cycles (1..65535)
//
// Ports:
//   clk_sys, reset_n           clock, async active-low reset
//   ioctl_*                    data_io download bus (input)
//   status_rst, button_rst     level reset requests, active high
//   core_reset                 active-high core reset
//   dl_we/dl_addr/dl_data/dl_slot  filtered, registered write bus
//   loaded                     per-slot loaded flags
//   dl_len                     byte count of the last completed download
//   led                        registered ~ioctl_download
//   dl_sum                     (DL_CHECKSUM_EN only) byte checksum
// ============================================================================
module dl_boot_ctrl #(
    parameter int N_SLOTS    = 2,
    parameter int REQ_MASK   = 1,
    parameter int AW         = 16,
    parameter int RST_CYCLES = 1024
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic               status_rst,
    input  logic               button_rst,
    output logic               core_reset,
    output logic               dl_we,
    output logic [AW-1:0]      dl_addr,
    output logic [7:0]         dl_data,
    output logic [7:0]         dl_slot,
`ifdef DL_CHECKSUM_EN
    output logic [7:0]         dl_sum,
`endif
    output logic [N_SLOTS-1:0] loaded,
    output logic [AW:0]        dl_len,
    output logic               led
);

    typedef enum logic [1:0] {
        S_WAIT_ROM = 2'd0,
        S_DL       = 2'd1,
        S_STRETCH  = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    localparam logic [N_SLOTS-1:0] MASK     = N_SLOTS'(REQ_MASK);
    localparam logic [15:0]        RST_LOAD = 16'(RST_CYCLES - 1);
    localparam logic [AW:0]        CNT_ONE  = {{AW{1'b0}}, 1'b1};

    // One-hot decode of a slot index; all zeros when the index is out of range.
    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [7:0] idx);
        logic [N_SLOTS-1:0] oh;
        for (int i = 0; i < N_SLOTS; i++) begin
            oh[i] = (idx == 8'(i));
        end
        return oh;
    endfunction

    state_t             r_state;
    logic               r_core_reset;
    logic [7:0]         r_slot;
    logic [AW:0]        r_cnt;
    logic [15:0]        r_rst_cnt;
    logic [N_SLOTS-1:0] r_loaded;
    logic [AW:0]        r_dl_len;
    logic               r_prev_run;
    logic               r_dl_d;
    logic               r_req_d;
    logic               r_led;
    logic               r_dl_we;
    logic [AW-1:0]      r_dl_addr;
    logic [7:0]         r_dl_data;
    logic [7:0]         r_dl_slot;

    logic               w_start;
    logic               w_end;
    logic               w_req;
    logic [N_SLOTS-1:0] w_slot_oh;
    logic [N_SLOTS-1:0] w_new_oh;
    logic               w_slot_in_mask;
    logic               w_new_in_mask;
    logic               w_addr_ok;
    logic               w_fwd;
    logic [N_SLOTS-1:0] w_loaded_nx;

    assign w_start        = ioctl_download & ~r_dl_d;
    assign w_end          = ~ioctl_download & r_dl_d;
    assign w_req          = status_rst | button_rst;
    assign w_slot_oh      = slot_onehot(r_slot);
    assign w_new_oh       = slot_onehot(ioctl_index);
    assign w_slot_in_mask = |(w_slot_oh & MASK);
    assign w_new_in_mask  = |(w_new_oh & MASK);
    assign w_addr_ok      = ((ioctl_addr >> AW) == 25'd0);
    // A write is forwarded only inside an active download to a valid slot.
    assign w_fwd          = ioctl_wr & (r_state == S_DL) & ~w_end & (|w_slot_oh) & w_addr_ok;
    // An empty download leaves the loaded flags untouched.
    assign w_loaded_nx    = r_loaded | ((r_cnt != '0) ? w_slot_oh : '0);

    // Boot FSM: state, core_reset, byte/stretch counters and download bookkeeping.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_WAIT_ROM;
            r_core_reset <= 1'b1;
            r_slot       <= 8'd0;
            r_cnt        <= '0;
            r_rst_cnt    <= 16'd0;
            r_loaded     <= '0;
            r_dl_len     <= '0;
            r_prev_run   <= 1'b0;
            r_dl_d       <= 1'b0;
            r_req_d      <= 1'b0;
            r_led        <= 1'b1;
        end else begin
            r_dl_d  <= ioctl_download;
            r_req_d <= w_req;
            r_led   <= ~ioctl_download;
            // The byte count saturates at 2^AW (top bit set).
            if (w_fwd && !r_cnt[AW]) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_start) begin
                r_state    <= S_DL;
                r_cnt      <= '0;
                r_slot     <= ioctl_index;
                r_prev_run <= (r_state == S_RUN);
                // Only a required slot pulls the core into reset; an optional
                // slot reloaded while running keeps the core alive.
                if (w_new_in_mask) begin
                    r_core_reset <= 1'b1;
                end else begin
                    r_core_reset <= r_core_reset;
                end
            end else begin
                case (r_state)
                    S_WAIT_ROM: begin
                        r_core_reset <= 1'b1;
                    end
                    S_DL: begin
                        if (w_end) begin
                            if ((r_cnt != '0) && (|w_slot_oh)) begin
                                r_loaded <= w_loaded_nx;
                                r_dl_len <= r_cnt;
                            end
                            if (r_prev_run && !w_slot_in_mask) begin
                                r_state      <= S_RUN;
                                r_core_reset <= 1'b0;
                            end else if ((w_loaded_nx & MASK) == MASK) begin
                                r_state      <= S_STRETCH;
                                r_rst_cnt    <= RST_LOAD;
                                r_core_reset <= 1'b1;
                            end else begin
                                r_state      <= S_WAIT_ROM;
                                r_core_reset <= 1'b1;
                            end
                        end
                    end
                    S_STRETCH: begin
                        r_core_reset <= 1'b1;
                        // The cycle in which a request is first seen released
                        // also reloads, so RST_CYCLES full cycles follow it.
                        if (w_req || r_req_d) begin
                            r_rst_cnt <= RST_LOAD;
                        end else if (r_rst_cnt == 16'd0) begin
                            r_state      <= S_RUN;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt - 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (w_req) begin
                            r_state      <= S_STRETCH;
                            r_rst_cnt    <= RST_LOAD;
                            r_core_reset <= 1'b1;
                        end else begin
                            r_core_reset <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= S_WAIT_ROM;
                        r_core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Registered download write bus; fields hold their last value between writes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_we   <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= 8'd0;
            r_dl_slot <= 8'd0;
        end else begin
            r_dl_we <= w_fwd;
            if (w_fwd) begin
                r_dl_addr <= ioctl_addr[AW-1:0];
                r_dl_data <= ioctl_dout;
                r_dl_slot <= r_slot;
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] r_sum;

    // Running modulo-256 sum of forwarded bytes, restarted on each download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= 8'd0;
        end else if (w_start) begin
            r_sum <= 8'd0;
        end else if (w_fwd) begin
            r_sum <= r_sum + ioctl_dout;
        end
    end

    assign dl_sum = r_sum;
`endif

    assign core_reset = r_core_reset;
    assign dl_we      = r_dl_we;
    assign dl_addr    = r_dl_addr;
    assign dl_data    = r_dl_data;
    assign dl_slot    = r_dl_slot;
    assign loaded     = r_loaded;
    assign dl_len     = r_dl_len;
    assign led        = r_led;

endmodule

// File: tb/tb_dl_boot_ctrl.sv
// ============================================================================
// tb_dl_boot_ctrl
// ----------------------------------------------------------------------------
// Directed + randomized bench for dl_boot_ctrl with default parameters.
// A small model tracks which slots are loaded, the last download length and
// the byte sum; reset durations are derived from RST_CYCLES directly.
// ============================================================================
module tb_dl_boot_ctrl;

    localparam int N_SLOTS    = 2;
    localparam int AW         = 16;
    localparam int RST_CYCLES = 1024;
    localparam int LIMIT      = 5000;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b0;
    logic               ioctl_download = 1'b0;
    logic [7:0]         ioctl_index = 8'd0;
    logic               ioctl_wr = 1'b0;
    logic [24:0]        ioctl_addr = 25'd0;
    logic [7:0]         ioctl_dout = 8'd0;
    logic               status_rst = 1'b0;
    logic               button_rst = 1'b0;
    logic               core_reset;
    logic               dl_we;
    logic [AW-1:0]      dl_addr;
    logic [7:0]         dl_data;
    logic [7:0]         dl_slot;
`ifdef DL_CHECKSUM_EN
    logic [7:0]         dl_sum;
`endif
    logic [N_SLOTS-1:0] loaded;
    logic [AW:0]        dl_len;
    logic               led;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [N_SLOTS-1:0] m_loaded;
    int                 m_len;
    int                 m_cnt;
    int                 m_sum;
    int                 m_slot;

    dl_boot_ctrl dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .status_rst     (status_rst),
        .button_rst     (button_rst),
        .core_reset     (core_reset),
        .dl_we          (dl_we),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_slot        (dl_slot),
`ifdef DL_CHECKSUM_EN
        .dl_sum         (dl_sum),
`endif
        .loaded         (loaded),
        .dl_len         (dl_len),
        .led            (led)
    );

    always #5 clk_sys = ~clk_sys;

    // Watchdog so the run always terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run for a number of cycles and require core_reset to stay at one level.
    task automatic hold_check(input string tag, input int cycles, input logic exp_cr);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (core_reset !== exp_cr) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Count consecutive cycles with core_reset high, starting at the current sample.
    task automatic count_high(input int start, output int n);
        n = start;
        while (core_reset === 1'b1 && n < LIMIT) begin
            n++;
            tick();
        end
    endtask

    task automatic dl_begin(input int slot, input logic exp_cr);
        ioctl_download = 1'b1;
        ioctl_index    = 8'(slot);
        tick();
        chk("start_core_reset", 32'(core_reset), 32'(exp_cr));
        chk("start_led", 32'(led), 32'd0);
        m_slot = slot;
        m_cnt  = 0;
        m_sum  = 0;
    endtask

    task automatic dl_byte(input int addr, input int data);
        bit ok;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = 8'(data);
        tick();
        ioctl_wr = 1'b0;
        ok = (m_slot < N_SLOTS) && (addr < (1 << AW));
        chk("we", 32'(dl_we), 32'(ok));
        if (ok) begin
            chk("addr", 32'(dl_addr), 32'(addr % (1 << AW)));
            chk("data", 32'(dl_data), 32'(data));
            chk("slot", 32'(dl_slot), 32'(m_slot));
            m_cnt++;
            m_sum = (m_sum + data) % 256;
        end
        tick();
        chk("we_gap", 32'(dl_we), 32'd0);
    endtask

    task automatic dl_end();
        ioctl_download = 1'b0;
        tick();
        if (m_slot < N_SLOTS && m_cnt > 0) begin
            m_loaded[m_slot] = 1'b1;
            m_len            = m_cnt;
        end
        chk("end_loaded", 32'(loaded), 32'(m_loaded));
        chk("end_len", 32'(dl_len), 32'(m_len));
        chk("end_led", 32'(led), 32'd1);
`ifdef DL_CHECKSUM_EN
        chk("end_sum", 32'(dl_sum), 32'(m_sum));
`endif
    endtask

    initial begin
        int n;
        int hold;
        int nb;
        int addr;
        m_loaded = '0;
        m_len    = 0;
        m_cnt    = 0;
        m_sum    = 0;
        m_slot   = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_dl_we", 32'(dl_we), 32'd0);
        chk("rst_dl_addr", 32'(dl_addr), 32'd0);
        chk("rst_dl_data", 32'(dl_data), 32'd0);
        chk("rst_dl_slot", 32'(dl_slot), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_dl_len", 32'(dl_len), 32'd0);
        chk("rst_led", 32'(led), 32'd1);
`ifdef DL_CHECKSUM_EN
        chk("rst_dl_sum", 32'(dl_sum), 32'd0);
`endif
        reset_n = 1'b1;
        hold_check("wait_rom_idle", 20, 1'b1);

        // Out-of-range slot: nothing forwarded, still waiting for the ROM
        dl_begin(5, 1'b1);
        dl_byte(0, 8'hAA);
        dl_byte(1, 8'hBB);
        dl_end();
        hold_check("bad_slot_stays_reset", 30, 1'b1);

        // Required slot 0: four bytes, then exactly RST_CYCLES of reset
        dl_begin(0, 1'b1);
        dl_byte(0, 8'h11);
        dl_byte(1, 8'h22);
        dl_byte(2, 8'h33);
        dl_byte(3, 8'h44);
        dl_end();
        count_high(0, n);
        chk("boot_stretch_len", 32'(n), 32'(RST_CYCLES));
        chk("boot_run", 32'(core_reset), 32'd0);

        // Random-length user reset request from a random source
        hold = $urandom_range(1, 12);
        if ($urandom_range(0, 1) == 0) button_rst = 1'b1;
        else status_rst = 1'b1;
        n = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (core_reset === 1'b1) n++;
        end
        button_rst = 1'b0;
        status_rst = 1'b0;
        tick();
        count_high(n, n);
        chk("req_stretch_rand", 32'(n), 32'(hold + RST_CYCLES));

        // Button held for 10 cycles
        button_rst = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_reset === 1'b1) n++;
        end
        button_rst = 1'b0;
        tick();
        count_high(n, n);
        chk("button_stretch_10", 32'(n), 32'(10 + RST_CYCLES));

        // Optional slot 1 while running: no reset pulse
        dl_begin(1, 1'b0);
        dl_byte($urandom_range(0, 16'hFFFF), $urandom_range(0, 255));
        dl_byte($urandom_range(0, 16'hFFFF), $urandom_range(0, 255));
        dl_end();
        chk("opt_loaded", 32'(loaded), 32'd3);
        chk("opt_len", 32'(dl_len), 32'd2);
        hold_check("opt_run_kept", 20, 1'b0);

`ifdef DL_CHECKSUM_EN
        dl_begin(1, 1'b0);
        dl_byte(10, 8'hFF);
        dl_byte(11, 8'h02);
        dl_end();
        chk("sum_ff_02", 32'(dl_sum), 32'h01);
`endif

        // Random slot-1 downloads with a mix of out-of-range addresses
        for (int it = 0; it < 6; it++) begin
            dl_begin(1, 1'b0);
            nb = $urandom_range(0, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) addr = 32'h10000 + $urandom_range(0, 255);
                else addr = $urandom_range(0, 16'hFFFF);
                dl_byte(addr, $urandom_range(0, 255));
            end
            dl_end();
            hold_check("rand_run_kept", 3, 1'b0);
        end

        // Reload slot 0 while running, then abort the stretch with slot 1
        dl_begin(0, 1'b1);
        dl_byte(5, 8'h77);
        dl_end();
        hold_check("reload_stretch", 100, 1'b1);
        dl_begin(1, 1'b1);
        dl_byte(6, 8'h88);
        dl_end();
        count_high(0, n);
        chk("abort_restretch_len", 32'(n), 32'(RST_CYCLES));

        // Out-of-range address dropped, then reset_n pulsed mid-download
        dl_begin(0, 1'b1);
        dl_byte(32'h10000, 8'h5A);
        dl_byte(7, 8'h66);
        reset_n = 1'b0;
        tick();
        chk("midrst_loaded", 32'(loaded), 32'd0);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_len", 32'(dl_len), 32'd0);
        reset_n  = 1'b1;
        m_loaded = '0;
        m_len    = 0;
        m_cnt    = 0;
        m_sum    = 0;
        tick();
        dl_end();
        chk("midrst_end_loaded", 32'(loaded), 32'd0);
        hold_check("midrst_wait_rom", 20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
